// File: rtl/shared_gain_sequencer.sv
// Four-channel gain stage that time-shares one signed multiplier, one channel per cycle.
// Define SHARED_GAIN_SATURATE_EN to clamp results instead of wrapping them.
module shared_gain_sequencer #(
  parameter int W      = 16,
  parameter int GAIN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  input  logic [GAIN_W-1:0]   gain0,
  input  logic [GAIN_W-1:0]   gain1,
  input  logic [GAIN_W-1:0]   gain2,
  input  logic [GAIN_W-1:0]   gain3,
  input  logic [7:0]          jack,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  output logic                busy
);

  localparam int PW = W + GAIN_W + 1;

  typedef enum logic [1:0] {IDLE, MUL, COMMIT} state_t;

  state_t state, state_next;
  logic [1:0] ch, ch_next;
  logic sample_clk_q;
  logic start;

  logic signed [W-1:0]  snap_in   [4];
  logic [GAIN_W-1:0]    snap_gain [4];
  logic [3:0]           snap_jack;
  logic signed [W-1:0]  hold      [4];

  logic signed [W-1:0]  mult_a;
  logic signed [GAIN_W:0] mult_b;
  logic signed [PW-1:0] product;
  logic signed [W+1:0]  prod_sh;
  logic signed [W-1:0]  reduced;
  logic signed [W-1:0]  ch_result;
  logic                 unused_bits;

  assign start = sample_clk & ~sample_clk_q & (state == IDLE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= 2'd0;
    end else begin
      state <= state_next;
      ch    <= ch_next;
    end
  end

  always_comb begin
    state_next = state;
    ch_next    = ch;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = MUL;
          ch_next    = 2'd0;
        end
      end
      MUL: begin
        ch_next = ch + 2'd1;
        if (ch == 2'd3) state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The single shared multiplier; the gain is zero-extended so it is never negative.
  always_comb begin
    mult_a = snap_in[ch];
    mult_b = {1'b0, snap_gain[ch]};
  end

  assign product = PW'(mult_a) * PW'(mult_b);
  // Slicing off the low GAIN_W-1 bits is an arithmetic shift with floor rounding.
  assign prod_sh = product[PW-1:GAIN_W-1];

`ifdef SHARED_GAIN_SATURATE_EN
  localparam logic signed [W+1:0] SAT_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SAT_MIN = {2'b11, 1'b1, {(W-1){1'b0}}};

  always_comb begin
    reduced = prod_sh[W-1:0];
    if (prod_sh > SAT_MAX)
      reduced = {1'b0, {(W-1){1'b1}}};
    else if (prod_sh < SAT_MIN)
      reduced = {1'b1, {(W-1){1'b0}}};
  end
`else
  assign reduced = prod_sh[W-1:0];
`endif

  assign ch_result   = snap_jack[ch] ? reduced : '0;
  assign unused_bits = ^{product[GAIN_W-2:0], prod_sh[W+1:W], jack[7:4]};

  always_ff @(posedge clk) begin
    sample_clk_q <= sample_clk;
    if (rst) begin
      snap_jack   <= 4'd0;
      sample_out0 <= '0;
      sample_out1 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
      for (int i = 0; i < 4; i++) begin
        snap_in[i]   <= '0;
        snap_gain[i] <= '0;
        hold[i]      <= '0;
      end
    end else begin
      if (start) begin
        snap_in[0]   <= sample_in0;
        snap_in[1]   <= sample_in1;
        snap_in[2]   <= sample_in2;
        snap_in[3]   <= sample_in3;
        snap_gain[0] <= gain0;
        snap_gain[1] <= gain1;
        snap_gain[2] <= gain2;
        snap_gain[3] <= gain3;
        snap_jack    <= jack[3:0];
      end
      if (state == MUL) hold[ch] <= ch_result;
      // All four outputs move together so no partial result is ever visible.
      if (state == COMMIT) begin
        sample_out0 <= hold[0];
        sample_out1 <= hold[1];
        sample_out2 <= hold[2];
        sample_out3 <= hold[3];
      end
    end
  end

endmodule

// File: tb/tb_shared_gain_sequencer.sv
// Scoreboard bench for shared_gain_sequencer; honours SHARED_GAIN_SATURATE_EN like the design.
module tb_shared_gain_sequencer;

  localparam int W = 16;
  localparam int GAIN_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_clk = 1'b0;
  logic signed [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [GAIN_W-1:0] g0 = '0, g1 = '0, g2 = '0, g3 = '0;
  logic [7:0] jack = '0;
  logic signed [W-1:0] out0, out1, out2, out3;
  logic busy;

  shared_gain_sequencer #(.W(W), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
    .gain0(g0), .gain1(g1), .gain2(g2), .gain3(g3), .jack(jack),
    .sample_out0(out0), .sample_out1(out1), .sample_out2(out2), .sample_out3(out3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int due;
    logic signed [W-1:0] v0;
    logic signed [W-1:0] v1;
    logic signed [W-1:0] v2;
    logic signed [W-1:0] v3;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int next_ok = 0;
  logic rst_s = 1'b1;
  logic sc_prev = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  function automatic logic signed [W-1:0] model(input logic signed [W-1:0] s,
                                                  input logic [GAIN_W-1:0] g,
                                                  input logic en);
    longint p, r;
    logic signed [W-1:0] res;
    p = longint'(s) * longint'({24'd0, g});
    r = p >>> (GAIN_W - 1);
`ifdef SHARED_GAIN_SATURATE_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    res = r[W-1:0];
    return en ? res : '0;
  endfunction

  // Scoreboard: expected outputs become current on their due cycle and must hold until the next one.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_s) begin
        sb.delete();
        cur_exp = '0;
      end else if (sb.size() > 0) begin
        if (sb[0].due == cyc) cur_exp = sb.pop_front();
        else if (sb[0].due < cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_due: entry due %0d still pending at %0d", sb[0].due, cyc);
          void'(sb.pop_front());
        end
      end
      checks++;
      if ({out0, out1, out2, out3} !== {cur_exp.v0, cur_exp.v1, cur_exp.v2, cur_exp.v3}) begin
        errors++;
        $display("[TB] FAIL sb_outputs cyc %0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                 cyc, out0, out1, out2, out3, cur_exp.v0, cur_exp.v1, cur_exp.v2, cur_exp.v3);
      end
    end
  end

  // Drives one sample_clk pulse at the current negedge and records what the bench expects.
  task automatic strobe(input logic signed [W-1:0] a0, a1, a2, a3,
                        input logic [GAIN_W-1:0] b0, b1, b2, b3,
                        input logic [7:0] j);
    exp_t e;
    in0 = a0; in1 = a1; in2 = a2; in3 = a3;
    g0 = b0; g1 = b1; g2 = b2; g3 = b3;
    jack = j;
    sample_clk = 1'b1;
    if (!sc_prev && !rst && (cyc + 1 >= next_ok)) begin
      e.due = cyc + 6;
      e.v0 = model(a0, b0, j[0]);
      e.v1 = model(a1, b1, j[1]);
      e.v2 = model(a2, b2, j[2]);
      e.v3 = model(a3, b3, j[3]);
      sb.push_back(e);
      next_ok = cyc + 7;
    end
    @(negedge clk);
    sample_clk = 1'b0;
    sc_prev = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sample_clk = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if ({out0, out1, out2, out3} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %0d %0d %0d %0d expected 0", out0, out1, out2, out3);
    end
    rst = 1'b0;
    next_ok = 0;
    @(negedge clk);
  endtask

  task automatic test_gains;
    strobe(16'sd1000, -16'sd1000, 16'sd1234, -16'sd1, 8'h80, 8'h40, 8'h00, 8'h01, 8'h0F);
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL gains_busy step %0d: got %b expected 1", i, busy);
      end
      if (i < 5) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gains_busy_end: got %b expected 0", busy);
    end
    checks++;
    if ({out0, out1, out2, out3} !== {16'sd1000, -16'sd500, 16'sd0, -16'sd1}) begin
      errors++;
      $display("[TB] FAIL gains_values: got %0d %0d %0d %0d expected 1000 -500 0 -1",
               out0, out1, out2, out3);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overflow;
    logic signed [W-1:0] e0, e1;
`ifdef SHARED_GAIN_SATURATE_EN
    e0 = 16'sd32767;
    e1 = -16'sd32768;
`else
    e0 = -16'sd5771;
    e1 = 16'sd256;
`endif
    strobe(16'sd30000, -16'sd32768, 16'sd0, 16'sd0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF);
    repeat (5) @(negedge clk);
    checks++;
    if (out0 !== e0 || out1 !== e1) begin
      errors++;
      $display("[TB] FAIL overflow: got %0d %0d expected %0d %0d", out0, out1, e0, e1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    strobe(16'sd100, 16'sd200, 16'sd300, 16'sd400, 8'h80, 8'h80, 8'h80, 8'h80, 8'h0F);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_busy_mid: got %b expected 1", busy);
    end
    strobe(16'sd7, 16'sd7, 16'sd7, 16'sd7, 8'h80, 8'h80, 8'h80, 8'h80, 8'h0F);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got %b expected 0", busy);
    end
    strobe(-16'sd100, -16'sd200, 16'sd3000, 16'sd4000, 8'h40, 8'h20, 8'hC0, 8'h80, 8'h0F);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept_t6: got %b expected 1", busy);
    end
    repeat (7) @(negedge clk);
  endtask

  task automatic test_jack_snapshot;
    strobe(16'sd111, 16'sd222, 16'sd333, 16'sd5000, 8'h80, 8'h80, 8'h80, 8'h80, 8'h07);
    @(negedge clk);
    in3 = 16'sd9999;
    in0 = -16'sd5;
    g1 = 8'h10;
    jack = 8'hFF;
    repeat (4) @(negedge clk);
    checks++;
    if ({out0, out1, out2, out3} !== {16'sd111, 16'sd222, 16'sd333, 16'sd0}) begin
      errors++;
      $display("[TB] FAIL jack_snapshot: got %0d %0d %0d %0d expected 111 222 333 0",
               out0, out1, out2, out3);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    strobe(16'sd500, 16'sd600, 16'sd700, 16'sd800, 8'h80, 8'h80, 8'h80, 8'h80, 8'h0F);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sample_clk = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || {out0, out1, out2, out3} !== '0) begin
      errors++;
      $display("[TB] FAIL abort_reset: busy %b outs %0d %0d %0d %0d expected 0", busy, out0, out1, out2, out3);
    end
    @(negedge clk);
    rst = 1'b0;
    sc_prev = 1'b1;
    next_ok = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_no_spurious step %0d: got %b expected 0", i, busy);
      end
    end
    sample_clk = 1'b0;
    @(negedge clk);
    sc_prev = 1'b0;
    strobe(16'sd42, 16'sd43, 16'sd44, 16'sd45, 8'h80, 8'h80, 8'h80, 8'h80, 8'h0F);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_restart: got %b expected 1", busy);
    end
    repeat (7) @(negedge clk);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      strobe(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             GAIN_W'($urandom), GAIN_W'($urandom), GAIN_W'($urandom), GAIN_W'($urandom),
             8'($urandom));
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_gains();
    test_overflow();
    test_back_to_back();
    test_jack_snapshot();
    test_reset_abort();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_gain_sequencer.md
SHARED_GAIN_SEQUENCER -- requirements
Module: shared_gain_sequencer

Interface
REQ-001 Parameter W, default 16: signed sample width.
REQ-002 Parameter GAIN_W, default 8: unsigned gain width; gain value g means g / 2^(GAIN_W-1), so 0x80 is unity.
REQ-003 rst  input  1: synchronous, active-high reset.
REQ-004 clk  input  1: single system clock.
REQ-005 sample_clk  input  1: sample strobe, synchronous to clk; each rising edge starts one sequence.
REQ-006 sample_in0..sample_in3  input  W each: signed input samples.
REQ-007 gain0..gain3  input  GAIN_W each: unsigned per-channel gains.
REQ-008 jack  input  8: jack[i] high enables channel i for i = 0..3; jack[7:4] are ignored.
REQ-009 sample_out0..sample_out3  output  W each: signed, registered results.
REQ-010 busy  output  1: high while a sequence is in progress.

Function
REQ-011 Edge detect: an edge occurs in the cycle where sample_clk=1 and its registered previous value is 0.
REQ-012 FSM states IDLE, MUL, COMMIT:
- IDLE -> MUL on an edge.
- MUL stays for exactly 4 cycles, one per channel, in order ch0..ch3.
- MUL -> COMMIT after ch3.
- COMMIT -> IDLE unconditionally.
REQ-013 On the edge cycle, snapshot sample_in0..3, gain0..3 and jack[3:0] into internal registers; later input changes do not affect the running sequence.
REQ-014 Exactly one signed W x (GAIN_W+1) multiplier is shared across the four channels; the gain is zero-extended.
REQ-015 Per channel: r = (snap_in * gain) >>> (GAIN_W-1), arithmetic shift with floor rounding, reduced to W bits per REQ-028/029.
REQ-016 If the snapped jack[i]=0, the channel i result is 0, whatever the gain.
REQ-017 Results go into holding registers during MUL; all four sample_out update together at the end of the COMMIT cycle.
REQ-018 Latency: if the edge is in cycle T, outputs show new values from cycle T+6 (MUL T+1..T+4, COMMIT T+5).
REQ-019 busy=1 from cycle T+1 through T+5 inclusive; busy=0 in IDLE.
REQ-020 An edge seen while busy=1 is ignored, not queued; outputs keep their previous committed values until the next accepted sequence.
REQ-021 An edge in the same cycle the FSM returns to IDLE (cycle T+6) is accepted.
REQ-022 Outputs are stable between commits; no intermediate values appear on sample_out.

Reset
REQ-023 While rst=1, state goes to IDLE, all sample_out go to 0, busy goes to 0, and holding/snapshot registers clear.
REQ-024 While rst=1, the previous-sample_clk register loads the current sample_clk, so no spurious edge is seen on release when sample_clk is held high.
REQ-025 Reset asserted mid-sequence aborts it; no partial commit occurs and outputs read 0 in the cycle after rst.
REQ-026 The first edge is accepted no earlier than the first cycle after rst deasserts.

Configuration
REQ-027 Macro SHARED_GAIN_SATURATE_EN selects the overflow behaviour.
REQ-028 With SHARED_GAIN_SATURATE_EN defined, results clamp to [-2^(W-1), 2^(W-1)-1].
REQ-029 Without SHARED_GAIN_SATURATE_EN, results are truncated to the low W bits (two's-complement wrap).

Verification
REQ-030 gain0=0x80, jack=0x0F, in0=1000, edge at T -> out0=1000 from T+6, busy high T+1..T+5.
REQ-031 gain1=0x40, in1=-1000 -> out1=-500; gain2=0x00, in2=1234 -> out2=0; gain3=0x01, in3=-1 -> out3=-1 (floor).
REQ-032 in0=30000, gain0=0xFF -> out0=32767 with macro, -5771 without; in1=-32768, gain1=0xFF -> -32768 with macro.
REQ-033 Second edge at T+3 -> ignored, one commit at T+6 only; edge at T+6 -> accepted, commit at T+12.
REQ-034 jack=0x07, in3=5000, gain3=0x80 -> out3=0; in3 changed at T+2 -> no effect on the committed values.
REQ-035 rst pulsed at T+3 with sample_clk held high through release -> outputs 0, busy 0, no sequence starts until the next true rising edge.
